// File: rtl/tlb_unit_if.sv
// Port bundle between CP0/pipeline (master) and the joint TLB (slave):
// TLB instruction operands and results plus the address-translation port.
interface tlb_unit_if;
  logic [2:0]  tlb_typeM;
  logic        stallM;
  logic        flushM;
  logic [31:0] cp0_entryHi;
  logic [31:0] cp0_pageMask;
  logic [31:0] cp0_entryLo0;
  logic [31:0] cp0_entryLo1;
  logic [31:0] cp0_index;
  logic [31:0] cp0_random;
  logic [31:0] tlb_entryHi;
  logic [31:0] tlb_pageMask;
  logic [31:0] tlb_entryLo0;
  logic [31:0] tlb_entryLo1;
  logic [31:0] tlb_index;
  logic        lk_req;
  logic [31:0] lk_vaddr;
  logic        lk_write;
  logic        lk_valid;
  logic [31:0] lk_paddr;
  logic        lk_miss;
  logic        lk_invalid;
  logic        lk_modified;
  logic        lk_cached;

  modport master (
    output tlb_typeM, stallM, flushM,
    output cp0_entryHi, cp0_pageMask, cp0_entryLo0, cp0_entryLo1, cp0_index, cp0_random,
    input  tlb_entryHi, tlb_pageMask, tlb_entryLo0, tlb_entryLo1, tlb_index,
    output lk_req, lk_vaddr, lk_write,
    input  lk_valid, lk_paddr, lk_miss, lk_invalid, lk_modified, lk_cached
  );

  modport slave (
    input  tlb_typeM, stallM, flushM,
    input  cp0_entryHi, cp0_pageMask, cp0_entryLo0, cp0_entryLo1, cp0_index, cp0_random,
    output tlb_entryHi, tlb_pageMask, tlb_entryLo0, tlb_entryLo1, tlb_index,
    input  lk_req, lk_vaddr, lk_write,
    output lk_valid, lk_paddr, lk_miss, lk_invalid, lk_modified, lk_cached
  );
endinterface

// File: rtl/tlb_unit.sv
// Joint TLB: executes TLBWI/TLBWR/TLBR/TLBP for CP0 and translates virtual
// addresses for fetch/memory with one cycle of latency (4KB pages only).
module tlb_unit #(
  parameter int TLB_ENTRIES = 32,
  parameter int IDX_W       = 5
) (
  input logic       clk,
  input logic       rst,
  tlb_unit_if.slave bus
);

  localparam logic [2:0] OP_TLBP  = 3'b001;
  localparam logic [2:0] OP_TLBR  = 3'b010;
  localparam logic [2:0] OP_TLBWI = 3'b011;
  localparam logic [2:0] OP_TLBWR = 3'b100;

  logic [18:0] r_vpn2     [TLB_ENTRIES];
  logic [7:0]  r_asid     [TLB_ENTRIES];
  logic [31:0] r_pageMask [TLB_ENTRIES];
  logic        r_g        [TLB_ENTRIES];
  logic [19:0] r_pfn0     [TLB_ENTRIES];
  logic [19:0] r_pfn1     [TLB_ENTRIES];
  logic [2:0]  r_c0       [TLB_ENTRIES];
  logic [2:0]  r_c1       [TLB_ENTRIES];
  logic        r_d0       [TLB_ENTRIES];
  logic        r_d1       [TLB_ENTRIES];
  logic        r_v0       [TLB_ENTRIES];
  logic        r_v1       [TLB_ENTRIES];

  logic        r_lkValid;
  logic [31:0] r_lkPaddr;
  logic        r_lkMiss;
  logic        r_lkInvalid;
  logic        r_lkModified;
  logic        r_lkCached;

  logic             w_wrEn;
  logic [IDX_W-1:0] w_wrIdx;
  logic [IDX_W-1:0] w_rdIdx;
  logic             w_probeHit;
  logic [IDX_W-1:0] w_probeIdx;
  logic             w_lkHit;
  logic [IDX_W-1:0] w_lkIdx;
  logic [19:0]      w_lkPfn;
  logic [2:0]       w_lkC;
  logic             w_lkD;
  logic             w_lkV;
  logic [31:0]      w_nxtPaddr;
  logic             w_nxtMiss;
  logic             w_nxtInvalid;
  logic             w_nxtModified;
  logic             w_nxtCached;
  logic             w_unused;

  assign w_unused = &{1'b0, bus.cp0_entryHi[12:8], bus.cp0_entryLo0[31:26],
                      bus.cp0_entryLo1[31:26], bus.cp0_index[31:IDX_W],
                      bus.cp0_random[31:IDX_W], OP_TLBP};

  // Writes commit only when the memory stage actually retires the instruction.
  always_comb begin
    w_wrEn  = ((bus.tlb_typeM == OP_TLBWI) || (bus.tlb_typeM == OP_TLBWR))
              && !bus.stallM && !bus.flushM;
    w_wrIdx = (bus.tlb_typeM == OP_TLBWR) ? bus.cp0_random[IDX_W-1:0]
                                          : bus.cp0_index[IDX_W-1:0];
    w_rdIdx = bus.cp0_index[IDX_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TLB_ENTRIES; i++) begin
        r_vpn2[i]     <= '0;
        r_asid[i]     <= '0;
        r_pageMask[i] <= '0;
        r_g[i]        <= 1'b0;
        r_pfn0[i]     <= '0;
        r_pfn1[i]     <= '0;
        r_c0[i]       <= '0;
        r_c1[i]       <= '0;
        r_d0[i]       <= 1'b0;
        r_d1[i]       <= 1'b0;
        r_v0[i]       <= 1'b0;
        r_v1[i]       <= 1'b0;
      end
    end else if (w_wrEn) begin
      r_vpn2[w_wrIdx]     <= bus.cp0_entryHi[31:13];
      r_asid[w_wrIdx]     <= bus.cp0_entryHi[7:0];
      r_pageMask[w_wrIdx] <= bus.cp0_pageMask;
      r_g[w_wrIdx]        <= bus.cp0_entryLo0[0] & bus.cp0_entryLo1[0];
      r_pfn0[w_wrIdx]     <= bus.cp0_entryLo0[25:6];
      r_pfn1[w_wrIdx]     <= bus.cp0_entryLo1[25:6];
      r_c0[w_wrIdx]       <= bus.cp0_entryLo0[5:3];
      r_c1[w_wrIdx]       <= bus.cp0_entryLo1[5:3];
      r_d0[w_wrIdx]       <= bus.cp0_entryLo0[2];
      r_d1[w_wrIdx]       <= bus.cp0_entryLo1[2];
      r_v0[w_wrIdx]       <= bus.cp0_entryLo0[1];
      r_v1[w_wrIdx]       <= bus.cp0_entryLo1[1];
    end
  end

  // Scanning from the top down lets the lowest matching index win.
  always_comb begin
    w_probeHit = 1'b0;
    w_probeIdx = '0;
    w_lkHit    = 1'b0;
    w_lkIdx    = '0;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      if ((r_vpn2[i] == bus.cp0_entryHi[31:13]) &&
          (r_g[i] || (r_asid[i] == bus.cp0_entryHi[7:0]))) begin
        w_probeHit = 1'b1;
        w_probeIdx = IDX_W'(i);
      end
      if ((r_vpn2[i] == bus.lk_vaddr[31:13]) &&
          (r_g[i] || (r_asid[i] == bus.cp0_entryHi[7:0]))) begin
        w_lkHit = 1'b1;
        w_lkIdx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    bus.tlb_entryHi  = {r_vpn2[w_rdIdx], 5'b0, r_asid[w_rdIdx]};
    bus.tlb_pageMask = r_pageMask[w_rdIdx];
    bus.tlb_entryLo0 = {6'b0, r_pfn0[w_rdIdx], r_c0[w_rdIdx], r_d0[w_rdIdx],
                        r_v0[w_rdIdx], r_g[w_rdIdx]};
    bus.tlb_entryLo1 = {6'b0, r_pfn1[w_rdIdx], r_c1[w_rdIdx], r_d1[w_rdIdx],
                        r_v1[w_rdIdx], r_g[w_rdIdx]};
    bus.tlb_index    = w_probeHit ? {{(32-IDX_W){1'b0}}, w_probeIdx} : 32'h8000_0000;
  end

  always_comb begin
    w_lkPfn = bus.lk_vaddr[12] ? r_pfn1[w_lkIdx] : r_pfn0[w_lkIdx];
    w_lkC   = bus.lk_vaddr[12] ? r_c1[w_lkIdx]   : r_c0[w_lkIdx];
    w_lkD   = bus.lk_vaddr[12] ? r_d1[w_lkIdx]   : r_d0[w_lkIdx];
    w_lkV   = bus.lk_vaddr[12] ? r_v1[w_lkIdx]   : r_v0[w_lkIdx];
  end

  // kseg0/kseg1 bypass the array; everything else is mapped, miss > invalid > modified.
  always_comb begin
    w_nxtPaddr    = {20'b0, bus.lk_vaddr[11:0]};
    w_nxtMiss     = 1'b0;
    w_nxtInvalid  = 1'b0;
    w_nxtModified = 1'b0;
    w_nxtCached   = 1'b0;
    if (bus.lk_vaddr[31:30] == 2'b10) begin
      w_nxtPaddr  = {3'b0, bus.lk_vaddr[28:0]};
      w_nxtCached = ~bus.lk_vaddr[29];
    end else if (!w_lkHit) begin
      w_nxtMiss = 1'b1;
    end else begin
      w_nxtPaddr  = {w_lkPfn, bus.lk_vaddr[11:0]};
      w_nxtCached = (w_lkC == 3'b011);
      if (!w_lkV) begin
        w_nxtInvalid = 1'b1;
      end else if (bus.lk_write && !w_lkD) begin
        w_nxtModified = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lkValid    <= 1'b0;
      r_lkPaddr    <= '0;
      r_lkMiss     <= 1'b0;
      r_lkInvalid  <= 1'b0;
      r_lkModified <= 1'b0;
      r_lkCached   <= 1'b0;
    end else begin
      r_lkValid <= bus.lk_req;
      if (bus.lk_req) begin
        r_lkPaddr    <= w_nxtPaddr;
        r_lkMiss     <= w_nxtMiss;
        r_lkInvalid  <= w_nxtInvalid;
        r_lkModified <= w_nxtModified;
        r_lkCached   <= w_nxtCached;
      end
    end
  end

  assign bus.lk_valid    = r_lkValid;
  assign bus.lk_paddr    = r_lkPaddr;
  assign bus.lk_miss     = r_lkMiss;
  assign bus.lk_invalid  = r_lkInvalid;
  assign bus.lk_modified = r_lkModified;
  assign bus.lk_cached   = r_lkCached;

endmodule

// File: doc/tlb_unit.md
Name: tlb_unit

Overview:
- Joint TLB: the other end of the CP0 TLB interface. Consumes cp0_entryHi/pageMask/entryLo0/entryLo1/index/random and executes TLBWI/TLBWR/TLBR/TLBP.
- Returns tlb_entryHi/pageMask/entryLo0/entryLo1/tlb_index, which CP0 latches when tlb_typeM selects TLBR or TLBP.
- Also provides a one-cycle-latency address-translation port for the fetch and memory stages.
- Translation exceptions (miss/invalid/modified) are reported to the exception logic.

Parameters:
- TLB_ENTRIES, 32, number of entries. Must be a power of two.
- IDX_W, 5, log2(TLB_ENTRIES).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- tlb_typeM  in  3  3'b001 TLBP, 3'b010 TLBR, 3'b011 TLBWI, 3'b100 TLBWR; other values = none
- stallM  in  1  memory stage stalled; blocks writes
- flushM  in  1  memory stage flushed; blocks writes
- cp0_entryHi, cp0_pageMask, cp0_entryLo0, cp0_entryLo1, cp0_index, cp0_random  in  32 each  CP0 register values
- tlb_entryHi, tlb_pageMask, tlb_entryLo0, tlb_entryLo1  out  32 each  TLBR result (combinational)
- tlb_index  out  32  TLBP result (combinational)
- lk_req  in  1  translation request
- lk_vaddr  in  32  virtual address
- lk_write  in  1  request is a store
- lk_valid  out  1  result valid (registered)
- lk_paddr  out  32  physical address
- lk_miss  out  1  no matching entry
- lk_invalid  out  1  matched entry has V=0
- lk_modified  out  1  store to a page with D=0
- lk_cached  out  1  cacheable access

Behaviour:
- Entry fields:
  - VPN2[18:0] from entryHi[31:13]; ASID[7:0] from entryHi[7:0]; PageMask[31:0] stored verbatim.
  - G = entryLo0[0] & entryLo1[0].
  - Per half: PFN[19:0] from lo[25:6], C[2:0] from lo[5:3], D from lo[2], V from lo[1].
- Page size: only 4KB pages are translated. PageMask is stored and returned but ignored for matching.
- Match rule: VPN2 == va[31:13] && (G || ASID == cp0_entryHi[7:0]). Multiple matches resolve to the lowest index.
- Reset: all entry fields zero (V=0, G=0). lk_valid, lk_paddr, lk_miss, lk_invalid, lk_modified, lk_cached all 0.
- TLBWI / TLBWR writes:
  - TLBWI writes entry cp0_index[IDX_W-1:0]; TLBWR writes entry cp0_random[IDX_W-1:0].
  - Write occurs on the clock edge only when !stallM && !flushM. Otherwise the array is unchanged.
  - A lookup or TLBP in the write cycle sees the old contents.
- TLBR (combinational, valid whenever tlb_typeM==3'b010):
  - Source entry is cp0_index[IDX_W-1:0].
  - tlb_entryHi = {VPN2, 5'b0, ASID}
  - tlb_entryLo0 = {6'b0, PFN0, C0, D0, V0, G}; tlb_entryLo1 likewise for half 1.
  - tlb_pageMask = stored PageMask.
- TLBP (combinational):
  - Matches using cp0_entryHi.
  - Hit: tlb_index = {1'b0, zeros, idx}. Miss: tlb_index = 32'h80000000.
- Outputs are don't-care when tlb_typeM selects neither TLBR nor TLBP. Drive them with the TLBR/TLBP functions regardless.
- Lookup pipeline: a request in cycle N gives lk_valid=1 in cycle N+1 with registered results.
  - A new request may be issued every cycle.
  - No request gives lk_valid=0 next cycle; the other outputs hold their last values.
- Region decode:
  - va[31:30]==2'b10 (kseg0/kseg1): unmapped, paddr = {3'b0, va[28:0]}. Flags all 0. lk_cached = ~va[29].
  - All other regions are mapped. Half select = va[12]. paddr = {PFN, va[11:0]}. lk_cached = (C==3'b011).
- Flag priority: miss > invalid > modified. Only the highest is asserted; paddr is still driven.
  - modified = lk_write & V & ~D.
- Reset mid-operation clears lk_valid the next cycle; array contents are zeroed.

Test Plan:
- After reset, TLBP with cp0_entryHi=0x00404005 -> tlb_index=0x80000000. Lookup 0x00404123 -> lk_valid=1, lk_miss=1.
- TLBWI, cp0_index=3, entryHi=0x00404005, lo0=0x0000101E, lo1=0, no stall/flush. Then:
  - TLBP -> tlb_index=0x00000003.
  - TLBR -> tlb_entryLo0=0x0000101E, tlb_entryHi=0x00404005.
  - Lookup 0x00404123 load -> paddr=0x00040123, lk_cached=1, no flags.
- Same entry, lookup 0x00405123 (odd half, V=0) -> lk_invalid=1. Rewrite with lo0=0x0000101A (D=0), then store to 0x00404123 -> lk_modified=1.
- Change cp0_entryHi ASID to 0x06 (G=0) -> lookup misses. Rewrite entry with G=1 in both lo -> lookup hits.
- Lookup 0xBFC00000 -> paddr=0x1FC00000, lk_cached=0, no flags. Lookup 0x80001000 -> paddr=0x00001000, lk_cached=1.
- TLBWI with flushM=1 (and separately stallM=1) -> entry unchanged, verified by TLBR. TLBWR with cp0_random=0x1F writes entry 31. Two matching entries -> lowest index reported.
